ifetch_buf: RTL and testbench
=============================

// Module: ifetch_buf
// PURPOSE
//  Fetch-response stage directly downstream of the ifu. Takes one fetch request at a time
//  (valid + 32-bit target), issues it to instruction memory and captures the returned word
//  with its PC into a DEPTH-entry FIFO. The FIFO feeds decode over a valid/ready interface.
//  Returns o_TrgtV to the ifu when a request completes. A flush (jump/redirect) empties the
//  FIFO and drops any in-flight response.
// PARAMETERS
//  DEPTH  4  instruction FIFO entries; power of 2, >= 2
// PORTS
//  i_Clk      in   1      clock, all state on rising edge
//  i_Rst      in   1      reset, asynchronous, active-high
//  i_FetchV   in   1      fetch request valid (from ifu o_FetchV)
//  i_FetchT   in   32     fetch target byte address (from ifu o_FetchT)
//  o_TrgtV    out  1      1-cycle pulse: request completed, ifu may send next request
//  i_Flush    in   1      redirect: discard FIFO contents and outstanding request
//  o_MemReq   out  1      imem request, held until granted
//  o_MemAddr  out  32     imem word address, {target[31:2],2'b00}
//  i_MemGnt   in   1      imem accepts request this cycle (o_MemReq & i_MemGnt)
//  i_MemRspV  in   1      imem response valid; earliest one cycle after grant
//  i_MemRspD  in   32     imem response instruction word
//  i_MemErr   in   1      imem bus error, qualified by i_MemRspV
//  o_InstV    out  1      FIFO head valid (= not empty)
//  o_InstD    out  32     head instruction
//  o_InstPc   out  32     head PC
//  o_InstErr  out  1      head fault (bus error or misaligned target)
//  i_InstRdy  in   1      decode consumes head when o_InstV & i_InstRdy
//  o_Count    out  clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, pointers 0. Reset mid-transaction abandons it;
//   any later i_MemRspV is ignored (state is IDLE).
//  FSM states: IDLE, REQ, WAIT, DROP. One request outstanding at most.
//  IDLE: accept when i_FetchV & !i_Flush & o_Count<DEPTH; latch target.
//   Aligned target ([1:0]==0) -> REQ, o_MemReq=1 and o_MemAddr valid from next cycle.
//   Misaligned -> no memory access; next cycle push {D=0,PC=target,Err=1}, pulse o_TrgtV, stay IDLE.
//   i_FetchV while full or flushing: not accepted, no o_TrgtV; ifu keeps holding request.
//  REQ: o_MemReq held, o_MemAddr stable. On i_MemGnt -> WAIT (o_MemReq low next cycle).
//  WAIT: on i_MemRspV push {i_MemRspD, latched PC, i_MemErr} and pulse o_TrgtV same edge; -> IDLE.
//  Latency (no stall): FetchV accepted cycle T, MemReq T+1, Gnt T+1, Rsp T+2, o_InstV/o_TrgtV T+3.
//  Flush (takes effect at the edge where i_Flush=1): count=0, rd/wr pointers=0, no push that edge.
//   REQ & !i_MemGnt -> IDLE (request withdrawn). REQ & i_MemGnt -> DROP. WAIT & !i_MemRspV -> DROP.
//   WAIT & i_MemRspV -> IDLE, response discarded. DROP: wait for i_MemRspV, discard, -> IDLE.
//   Pending misaligned push is cancelled. No o_TrgtV for any flushed request.
//  FIFO: push and pop same cycle -> count unchanged. Pop when empty impossible (gated by o_InstV).
//   Pointers wrap modulo DEPTH. Push never happens when full (accept requires count<DEPTH;
//   count cannot grow while a request is outstanding). o_InstD/Pc/Err combinationally from head.
//  o_TrgtV never asserts in REQ or DROP; never two pulses for one accepted request.
// TESTING
//  1 Reset release, FetchV=1 T=0x100, Gnt in 1st cycle, Rsp D=0x12345678 next -> MemAddr=0x100,
//    o_TrgtV 1 cycle, o_InstV=1 InstD=0x12345678 InstPc=0x100 InstErr=0 at T+3.
//  2 InstRdy=0, 4 fetches 0x0,0x4,0x8,0xC -> o_Count=4, 5th FetchV not accepted (no MemReq);
//    InstRdy=1 one cycle -> count=3, 5th request accepted next cycle.
//  3 Flush in WAIT, Rsp arrives 2 cycles later -> FIFO empty, o_InstV=0, no o_TrgtV, state IDLE;
//    new fetch 0x200 then returns normally.
//  4 Flush same cycle as i_MemGnt in REQ -> DROP; following Rsp discarded; count stays 0.
//  5 FetchV T=0x102 -> no o_MemReq; entry PC=0x102 InstErr=1 InstD=0, o_TrgtV pulse.
//  6 Rsp with i_MemErr=1 -> entry InstErr=1; simultaneous push+pop at count=1 keeps count=1.

Source files
------------

// File: rtl/ifetch_buf.sv
// Fetch-response stage: one outstanding imem request, response captured with its PC into a DEPTH-entry FIFO for decode.
// Accept-to-head latency 3 cycles with no stall; requests stall while the FIFO is full, and decode backpressures via i_InstRdy.
module ifetch_buf #(
   parameter int DEPTH = 4
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   input  logic                   i_FetchV,
   input  logic [31:0]            i_FetchT,
   output logic                   o_TrgtV,
   input  logic                   i_Flush,
   output logic                   o_MemReq,
   output logic [31:0]            o_MemAddr,
   input  logic                   i_MemGnt,
   input  logic                   i_MemRspV,
   input  logic [31:0]            i_MemRspD,
   input  logic                   i_MemErr,
   output logic                   o_InstV,
   output logic [31:0]            o_InstD,
   output logic [31:0]            o_InstPc,
   output logic                   o_InstErr,
   input  logic                   i_InstRdy,
   output logic [$clog2(DEPTH):0] o_Count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} stateT;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        err;
   } entryT;

   stateT         state;
   stateT         stateNxt;
   logic [31:0]   trgtQ;
   logic          misPend;
   logic          trgtVQ;
   entryT         fifoMem [DEPTH];
   logic [AW-1:0] rdPtr;
   logic [AW-1:0] wrPtr;
   logic [CW-1:0] cntQ;
   logic          aligned;
   logic          accept;
   logic          pushMem;
   logic          pushMis;
   logic          push;
   logic          pop;
   entryT         pushEnt;
   entryT         headEnt;

   // The ifu holds i_FetchV until o_TrgtV, so the completion cycle must not re-accept the same request.
   assign aligned = (i_FetchT[1:0] == 2'b00);
   assign accept  = (state == S_IDLE) & i_FetchV & ~i_Flush & ~misPend & ~trgtVQ
                    & (cntQ < CW'(DEPTH));
   assign pushMem = (state == S_WAIT) & i_MemRspV & ~i_Flush;
   assign pushMis = misPend & ~i_Flush;
   assign push    = pushMem | pushMis;
   assign pop     = o_InstV & i_InstRdy;
   assign pushEnt = pushMis ? entryT'{inst: 32'h0, pc: trgtQ, err: 1'b1}
                            : entryT'{inst: i_MemRspD, pc: trgtQ, err: i_MemErr};

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state <= S_IDLE;
      end else begin
         state <= stateNxt;
      end
   end

   always_comb begin
      stateNxt = state;
      case (state)
         S_IDLE: if (accept && aligned) stateNxt = S_REQ;
         S_REQ: begin
            if (i_Flush)       stateNxt = i_MemGnt ? S_DROP : S_IDLE;
            else if (i_MemGnt) stateNxt = S_WAIT;
         end
         S_WAIT: begin
            if (i_MemRspV)    stateNxt = S_IDLE;
            else if (i_Flush) stateNxt = S_DROP;
         end
         S_DROP: if (i_MemRspV) stateNxt = S_IDLE;
         default: stateNxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_MemReq = (state == S_REQ);
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         trgtQ   <= '0;
         misPend <= 1'b0;
         trgtVQ  <= 1'b0;
         rdPtr   <= '0;
         wrPtr   <= '0;
         cntQ    <= '0;
      end else begin
         trgtVQ  <= push;
         misPend <= accept & ~aligned;
         if (accept) trgtQ <= i_FetchT;
         if (i_Flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cntQ  <= '0;
         end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            case ({push, pop})
               2'b10:   cntQ <= cntQ + CW'(1);
               2'b01:   cntQ <= cntQ - CW'(1);
               default: cntQ <= cntQ;
            endcase
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (push) fifoMem[wrPtr] <= pushEnt;
   end

   // Head fields are forced to zero when empty so reset leaves every output at 0.
   assign headEnt   = fifoMem[rdPtr];
   assign o_InstV   = (cntQ != '0);
   assign o_InstD   = o_InstV ? headEnt.inst : 32'h0;
   assign o_InstPc  = o_InstV ? headEnt.pc   : 32'h0;
   assign o_InstErr = o_InstV & headEnt.err;
   assign o_Count   = cntQ;
   assign o_TrgtV   = trgtVQ;
   assign o_MemAddr = {trgtQ[31:2], 2'b00};

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed bench for ifetch_buf: each step drives inputs, advances one clock and checks outputs 1 time unit later.
module tb_ifetch_buf;
   logic        clk = 1'b0;
   logic        rst;
   logic        fetchV;
   logic [31:0] fetchT;
   logic        trgtV;
   logic        flush;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memGnt;
   logic        memRspV;
   logic [31:0] memRspD;
   logic        memErr;
   logic        instV;
   logic [31:0] instD;
   logic [31:0] instPc;
   logic        instErr;
   logic        instRdy;
   logic [2:0]  count;

   int nTests = 0;
   int nFail  = 0;
   logic [31:0] drainPc [4];

   always #5 clk = ~clk;

   ifetch_buf #(.DEPTH(4)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_FetchV(fetchV), .i_FetchT(fetchT), .o_TrgtV(trgtV),
      .i_Flush(flush), .o_MemReq(memReq), .o_MemAddr(memAddr), .i_MemGnt(memGnt),
      .i_MemRspV(memRspV), .i_MemRspD(memRspD), .i_MemErr(memErr), .o_InstV(instV),
      .o_InstD(instD), .o_InstPc(instPc), .o_InstErr(instErr), .i_InstRdy(instRdy),
      .o_Count(count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Aligned fetch with grant in the first REQ cycle and response the cycle after; ends one cycle past o_TrgtV.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] d, input logic err);
      fetchV = 1'b1; fetchT = addr;
      tick();
      fetchV = 1'b0; memGnt = 1'b1;
      tick();
      memGnt = 1'b0; memRspV = 1'b1; memRspD = d; memErr = err;
      tick();
      memRspV = 1'b0; memErr = 1'b0;
      chk("fetch_trgtv", trgtV, 1);
      tick();
   endtask

   task automatic popOne();
      instRdy = 1'b1;
      tick();
      instRdy = 1'b0;
   endtask

   initial begin
      rst = 1'b1; fetchV = 1'b0; fetchT = '0; flush = 1'b0; memGnt = 1'b0;
      memRspV = 1'b0; memRspD = '0; memErr = 1'b0; instRdy = 1'b0;
      tick(); tick();
      chk("rst_instv", instV, 0);
      chk("rst_count", count, 0);
      chk("rst_memreq", memReq, 0);
      chk("rst_trgtv", trgtV, 0);
      chk("rst_memaddr", memAddr, 0);
      chk("rst_instd", instD, 0);
      rst = 1'b0;
      tick();

      // Basic fetch with cycle-by-cycle latency.
      fetchV = 1'b1; fetchT = 32'h100;
      tick();
      chk("t1_memreq", memReq, 1);
      chk("t1_memaddr", memAddr, 32'h100);
      chk("t1_instv_early", instV, 0);
      fetchV = 1'b0; memGnt = 1'b1;
      tick();
      chk("t1_memreq_low", memReq, 0);
      chk("t1_trgtv_early", trgtV, 0);
      memGnt = 1'b0; memRspV = 1'b1; memRspD = 32'h12345678;
      tick();
      memRspV = 1'b0;
      chk("t1_instv", instV, 1);
      chk("t1_instd", instD, 32'h12345678);
      chk("t1_instpc", instPc, 32'h100);
      chk("t1_insterr", instErr, 0);
      chk("t1_trgtv", trgtV, 1);
      chk("t1_count", count, 1);
      tick();
      chk("t1_trgtv_pulse", trgtV, 0);
      popOne();
      chk("t1_pop_count", count, 0);
      chk("t1_pop_instv", instV, 0);

      // Fill to DEPTH; the fifth request must wait for a pop.
      fetch(32'h0, 32'hA0, 1'b0);
      fetch(32'h4, 32'hA1, 1'b0);
      fetch(32'h8, 32'hA2, 1'b0);
      fetch(32'hC, 32'hA3, 1'b0);
      chk("t2_full", count, 4);
      fetchV = 1'b1; fetchT = 32'h10;
      tick();
      chk("t2_blocked_req", memReq, 0);
      tick();
      chk("t2_blocked_req2", memReq, 0);
      chk("t2_head_pc", instPc, 32'h0);
      instRdy = 1'b1;
      tick();
      instRdy = 1'b0;
      chk("t2_after_pop", count, 3);
      chk("t2_head_pc2", instPc, 32'h4);
      chk("t2_still_idle", memReq, 0);
      tick();
      chk("t2_accepted", memReq, 1);
      chk("t2_addr", memAddr, 32'h10);
      fetchV = 1'b0; memGnt = 1'b1;
      tick();
      memGnt = 1'b0; memRspV = 1'b1; memRspD = 32'hA4;
      tick();
      memRspV = 1'b0;
      chk("t2_refill", count, 4);
      tick();
      drainPc[0] = 32'h4; drainPc[1] = 32'h8; drainPc[2] = 32'hC; drainPc[3] = 32'h10;
      instRdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain_pc", instPc, drainPc[i]);
         tick();
      end
      instRdy = 1'b0;
      chk("t2_drained", count, 0);

      // Flush while waiting for the response.
      fetchV = 1'b1; fetchT = 32'h300;
      tick();
      fetchV = 1'b0; memGnt = 1'b1;
      tick();
      memGnt = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      memRspV = 1'b1; memRspD = 32'hDEAD;
      tick();
      memRspV = 1'b0;
      chk("t3_instv", instV, 0);
      chk("t3_count", count, 0);
      chk("t3_trgtv", trgtV, 0);
      chk("t3_memreq", memReq, 0);
      tick();
      chk("t3_trgtv2", trgtV, 0);
      fetch(32'h200, 32'h55, 1'b0);
      chk("t3_new_pc", instPc, 32'h200);
      chk("t3_new_d", instD, 32'h55);
      chk("t3_new_count", count, 1);
      popOne();

      // Flush coincident with grant: the late response must be dropped.
      fetchV = 1'b1; fetchT = 32'h400;
      tick();
      fetchV = 1'b0; memGnt = 1'b1; flush = 1'b1;
      tick();
      memGnt = 1'b0; flush = 1'b0;
      chk("t4_memreq", memReq, 0);
      tick();
      memRspV = 1'b1; memRspD = 32'hBAD;
      tick();
      memRspV = 1'b0;
      chk("t4_count", count, 0);
      chk("t4_instv", instV, 0);
      chk("t4_trgtv", trgtV, 0);
      fetch(32'h500, 32'h66, 1'b0);
      chk("t4_next_pc", instPc, 32'h500);
      chk("t4_next_count", count, 1);
      popOne();

      // Flush in REQ without grant withdraws the request.
      fetchV = 1'b1; fetchT = 32'h600;
      tick();
      fetchV = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4b_withdrawn", memReq, 0);
      fetch(32'h604, 32'h67, 1'b0);
      chk("t4b_pc", instPc, 32'h604);
      chk("t4b_count", count, 1);
      popOne();

      // Misaligned target produces a faulting entry with no memory access.
      fetchV = 1'b1; fetchT = 32'h102;
      tick();
      fetchV = 1'b0;
      chk("t5_no_req", memReq, 0);
      chk("t5_trgtv_early", trgtV, 0);
      tick();
      chk("t5_no_req2", memReq, 0);
      chk("t5_trgtv", trgtV, 1);
      chk("t5_instv", instV, 1);
      chk("t5_pc", instPc, 32'h102);
      chk("t5_err", instErr, 1);
      chk("t5_d", instD, 0);
      chk("t5_count", count, 1);
      tick();
      chk("t5_trgtv_pulse", trgtV, 0);
      popOne();

      // Bus error entry, then push and pop in the same cycle at count 1.
      fetch(32'h700, 32'hEE, 1'b1);
      chk("t6_err", instErr, 1);
      chk("t6_pc", instPc, 32'h700);
      fetchV = 1'b1; fetchT = 32'h704;
      tick();
      fetchV = 1'b0; memGnt = 1'b1;
      tick();
      memGnt = 1'b0; memRspV = 1'b1; memRspD = 32'h77; instRdy = 1'b1;
      tick();
      memRspV = 1'b0; instRdy = 1'b0;
      chk("t6_count", count, 1);
      chk("t6_pc2", instPc, 32'h704);
      chk("t6_err2", instErr, 0);
      chk("t6_d2", instD, 32'h77);
      chk("t6_trgtv", trgtV, 1);
      popOne();

      // Reset during WAIT: a later response is ignored.
      fetchV = 1'b1; fetchT = 32'h800;
      tick();
      fetchV = 1'b0; memGnt = 1'b1;
      tick();
      memGnt = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; memRspV = 1'b1; memRspD = 32'h99;
      tick();
      memRspV = 1'b0;
      chk("rst_mid_count", count, 0);
      chk("rst_mid_trgtv", trgtV, 0);
      tick();
      chk("rst_mid_trgtv2", trgtV, 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
